// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, FSM states and alignment helper for mem_access_unit
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RSP,
    ERR
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load lane select/extension and store byte-merge for a 32-bit word memory
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (lane)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (size)
      SZ_BYTE: load_data = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
      SZ_HALF: load_data = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
      default: load_data = word;
    endcase
  end

  // Sub-word stores replace only the addressed lane of the captured word.
  always_comb begin
    store_word = word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store initiator for a word memory; MEM_ACCESS_RANGE_CHECK_EN enables index range errors
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  localparam logic [AW-3:0] DEPTH_IDX = (AW-2)'(DEPTH);

  state_t        state, state_n;
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [31:0]   cap_word;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic          accept;
  logic          req_bad;
  logic          idx_over;
  logic [31:0]   align_word;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign accept   = req_valid && (state == IDLE);
  assign idx_over = (req_addr[AW-1:2] >= DEPTH_IDX);
  assign req_bad  = (req_size == SZ_ILLEGAL) || misaligned(req_size, req_addr[1:0]) ||
                    (idx_over && RANGE_EN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                              state_n = ERR;
          else if (!req_we || req_size != SZ_WORD)  state_n = RD;
          else                                      state_n = WR;
        end
      end
      RD:      state_n = lat_we ? WR : RSP;
      WR:      state_n = RSP;
      RSP:     state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Loads extract straight from the memory port; the write path merges into the captured word.
  assign align_word = (state == WR) ? cap_word : mem_rdata;

  mem_lane_align u_align (
    .word        (align_word),
    .lane        (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cap_word     <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        lat_we       <= req_we;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_addr     <= req_addr;
        lat_wdata    <= req_wdata;
        if (req_bad) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
      if (state == RD) begin
        cap_word <= mem_rdata;
        if (!lat_we) begin
          rsp_rdata_q <= load_data;
          rsp_err_q   <= 1'b0;
        end
      end
      if (state == WR) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP) || (state == ERR);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_rw    = (state == WR) ? MEM_WRITE : MEM_READ;
  assign mem_addr  = {2'b00, lat_addr[AW-1:2]};
  assign mem_wdata = (state == WR) ? store_word : 32'h0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-addressed data-memory interface: accepts byte/half/word load and store requests from the core and drives the memory's MemRW/addr/DataW/DataR port.
- Word-only memory is handled internally: sub-word stores become read-modify-write; loads are extracted and sign/zero-extended.
- Sits between the execute stage and the data memory, for multi-cycle use.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached memory; valid word index 0..DEPTH-1
- AW, 32, width of req_addr and mem_addr

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid&req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_err  out  1  valid with rsp_valid; misaligned/illegal size/out-of-range
- mem_rw  out  1  1=read, 0=write (memory writes on every clk edge while 0)
- mem_addr  out  AW  word index = latched req_addr[AW-1:2]
- mem_wdata  out  32  write word
- mem_rdata  in  32  combinational read data, valid while mem_rw=1

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rw=1, mem_addr=0, mem_wdata=0. mem_rw is 1 in every state except WR; it is never 0 in IDLE, because the memory would write.
- On accept: latch we, size, unsigned, addr, wdata. req_ready=1 only in IDLE.
- States and transitions:
  - IDLE -> ERR if size==3 or misaligned (half: addr[0]!=0; word: addr[1:0]!=0) or range error; no memory access.
  - IDLE -> RD for loads and for byte/half stores.
  - IDLE -> WR for word stores.
  - RD: mem_rw=1, mem_addr driven; mem_rdata captured at the clk edge. Load -> RSP; store -> WR.
  - WR: mem_rw=0, mem_wdata driven. Word store writes req_wdata. Byte/half store writes captured word with lane addr[1:0] (byte) or addr[1] (half) replaced by req_wdata[7:0]/[15:0]. WR -> RSP.
  - RSP: rsp_valid=1, rsp_err=0 -> IDLE. ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 -> IDLE.
- Load extraction: select lane from captured word by addr[1:0]; byte/half sign-extended unless req_unsigned; word passed through.
- Latency, accept edge to rsp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Next request can be accepted the cycle after rsp_valid.
- No response backpressure; rsp_valid is a single-cycle pulse.
- rsp_rdata/rsp_err hold their values until the next response; they are valid only with rsp_valid.
- Reset mid-operation: immediate return to IDLE with mem_rw=1. An in-flight store is aborted with no write and no response.
- Requests with req_valid=0 are ignored; inputs are don't-care outside the accept cycle.

Optional Feature:
- MEM_ACCESS_RANGE_CHECK_EN defined: word index >= DEPTH flags rsp_err via ERR with no memory access.
- Undefined: no range check; mem_addr passes the full word index.

Decomposition:
- Shared package mem_access_pkg:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
  - MEM_READ=1, MEM_WRITE=0
  - state enum IDLE/RD/WR/RSP/ERR
- One sub-module is natural: mem_lane_align, combinational. It does load lane select/extension and store byte-merge, and is shared by the FSM for both paths.

Test Plan:
- Memory word 17 = 56 after reset, load word addr 0x44 -> rsp_valid 2 cycles after accept, rsp_rdata=56, rsp_err=0, mem_rw stays 1 throughout.
- Word 5 = 0x80FF_7F01. Load byte signed addr 0x16 -> 0xFFFF_FFFF. Load byte unsigned 0x17 -> 0x0000_0080. Load half signed 0x14 -> 0x0000_7F01.
- Word 5 = 0x1122_3344, store byte 0xAB at 0x15 -> mem_rw=0 for exactly one cycle, word 5 = 0x1122_AB44, rsp 3 cycles after accept.
- Store half at 0x13 -> rsp_err=1 one cycle after accept, mem_rw never 0, memory unchanged. Load size=3 -> rsp_err=1.
- With MEM_ACCESS_RANGE_CHECK_EN, load at 0x100 (index 64) -> rsp_err=1, no access. Without it, no error.
- Assert rst during WR of word store 0xDEAD_BEEF at 0x08 -> mem_rw forced 1 immediately, no rsp_valid, req_ready=1 after release.
